// File: rtl/mac_wb_queue_pkg.sv
// Shared types for the MAC write-back queue: datapath width and the queued entry layout.
package mac_wb_queue_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] instr_tag;
    logic [31:0]     instr;
  } mac_wb_entry_t;
endpackage

// File: rtl/mac_wb_fifo.sv
// Generic in-order circular FIFO of mac_wb_entry_t with an explicit occupancy count
// and per-slot valid bits exported for destination tracking.
module mac_wb_fifo
  import mac_wb_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  mac_wb_entry_t             wdata_i,
  output mac_wb_entry_t             head_o,
  output logic [DEPTH-1:0]          vld_o,
  output logic [DEPTH-1:0][4:0]     rd_o,
  output logic [CNT_W-1:0]          count_o,
  output logic                      full_o,
  output logic                      empty_o
);
  mac_wb_entry_t    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             do_push;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    if (pop_i) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (do_push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_rd
    assign rd_o[i] = mem_q[i].rd_addr;
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign vld_o   = vld_q;
  assign count_o = cnt_q;
endmodule

// File: rtl/mac_wb_queue.sv
// MAC write-back queue: buffers MAC results for the shared RF write port, filters x0,
// flags dropped pushes and exports pending destinations. Option: MAC_WB_QUEUE_BYPASS_EN.
module mac_wb_queue
  import mac_wb_queue_pkg::*;
#(
  parameter  int DEPTH    = 4,
  parameter  int AFULL_TH = DEPTH-1,
  localparam int CNT_W    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_data,
  input  logic [4:0]       in_rd_addr,
  input  logic [XLEN-1:0]  in_instr_tag,
  input  logic [31:0]      in_instr,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [XLEN-1:0]  wb_data,
  output logic [4:0]       wb_rd_addr,
  output logic [XLEN-1:0]  wb_instr_tag,
  output logic [31:0]      wb_instr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             almost_full,
  output logic [31:0]      pending_rd,
  output logic             overflow_err
);
  mac_wb_entry_t        in_ent, head, wb_ent;
  logic [DEPTH-1:0]     slot_vld;
  logic [DEPTH-1:0][4:0] slot_rd;
  logic                 push_ok, fifo_push, fifo_pop, fifo_empty, bypass;
  logic                 overflow_q, overflow_d;

  assign in_ent  = '{data: in_data, rd_addr: in_rd_addr, instr_tag: in_instr_tag, instr: in_instr};
  assign push_ok = in_valid & ~freeze & (in_rd_addr != 5'd0);

`ifdef MAC_WB_QUEUE_BYPASS_EN
  // Empty queue with a ready port: hand the result straight through, never stored.
  assign bypass = fifo_empty & push_ok & wb_ready;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = push_ok & ~bypass;
  assign fifo_pop  = ~fifo_empty & wb_ready;

  mac_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (in_ent),
    .head_o  (head),
    .vld_o   (slot_vld),
    .rd_o    (slot_rd),
    .count_o (count),
    .full_o  (full),
    .empty_o (fifo_empty)
  );

  assign wb_ent       = bypass ? in_ent : head;
  assign wb_valid     = ~fifo_empty | bypass;
  assign wb_data      = wb_ent.data;
  assign wb_rd_addr   = wb_ent.rd_addr;
  assign wb_instr_tag = wb_ent.instr_tag;
  assign wb_instr     = wb_ent.instr;
  assign almost_full  = (count >= CNT_W'(AFULL_TH));

  always_comb begin
    pending_rd = '0;
    for (int i = 0; i < DEPTH; i++)
      if (slot_vld[i]) pending_rd[slot_rd[i]] = 1'b1;
  end

  // A full queue only drops when the head is not leaving in the same cycle.
  assign overflow_d = overflow_q | (push_ok & full & ~fifo_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign overflow_err = overflow_q;
endmodule

// File: tb/tb_mac_wb_queue.sv
// Directed bench for mac_wb_queue with hand-computed expectations.
module tb_mac_wb_queue;
  import mac_wb_queue_pkg::*;

  logic            clk = 1'b0, rst = 1'b1, freeze = 1'b0, in_valid = 1'b0, wb_ready = 1'b0;
  logic [XLEN-1:0] in_data = '0, in_instr_tag = '0;
  logic [4:0]      in_rd_addr = '0;
  logic [31:0]     in_instr = '0;
  logic            wb_valid, full, almost_full, overflow_err;
  logic [XLEN-1:0] wb_data, wb_instr_tag;
  logic [4:0]      wb_rd_addr;
  logic [31:0]     wb_instr, pending_rd;
  logic [2:0]      count;
  int              n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  mac_wb_queue dut (
    .clk(clk), .rst(rst), .freeze(freeze), .in_valid(in_valid), .in_data(in_data),
    .in_rd_addr(in_rd_addr), .in_instr_tag(in_instr_tag), .in_instr(in_instr),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd_addr(wb_rd_addr),
    .wb_instr_tag(wb_instr_tag), .wb_instr(wb_instr), .count(count), .full(full),
    .almost_full(almost_full), .pending_rd(pending_rd), .overflow_err(overflow_err)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d);
    in_valid = v; in_rd_addr = rd; in_data = d;
    in_instr_tag = {24'd0, 3'd0, rd}; in_instr = 32'hC0DE_0000 | d;
  endtask

  task automatic do_reset();
    rst = 1'b1; #2; rst = 1'b0; tick();
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_pending", pending_rd, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_wb_data", wb_data, 0);
    rst = 1'b0;
    tick();

    // single push with ready: one-cycle latency
    wb_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h1234; in_rd_addr = 5'd5; in_instr_tag = 32'd7; in_instr = 32'hDEAD_BEEF;
`ifdef MAC_WB_QUEUE_BYPASS_EN
    #1;
    chk("byp_valid", wb_valid, 1);
    chk("byp_data", wb_data, 32'h1234);
    chk("byp_pending", pending_rd, 0);
    tick();
    drive(1'b0, 5'd0, 32'd0);
    chk("byp_count", count, 0);
`else
    tick();
    drive(1'b0, 5'd0, 32'd0);
    chk("t1_valid", wb_valid, 1);
    chk("t1_data", wb_data, 32'h1234);
    chk("t1_rd", wb_rd_addr, 5);
    chk("t1_tag", wb_instr_tag, 7);
    chk("t1_instr", wb_instr, 32'hDEAD_BEEF);
    chk("t1_pending", pending_rd, 32'h20);
    tick();
    chk("t1_empty", wb_valid, 0);
    chk("t1_pending0", pending_rd, 0);
    chk("t1_count0", count, 0);
`endif

    // fill to full with the port stalled
    wb_ready = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      drive(1'b1, 5'(r), 32'h100 + r);
      tick();
      chk("fill_count", count, r);
      chk("fill_afull", almost_full, r >= 3);
      chk("fill_full", full, r == 4);
    end
    drive(1'b0, 5'd0, 32'd0);
    chk("fill_pending", pending_rd, 32'h1E);
    chk("fill_head_stable", wb_rd_addr, 1);

    // push while full and stalled: dropped
    drive(1'b1, 5'd9, 32'h909);
    tick();
    chk("ovf_set", overflow_err, 1);
    chk("ovf_count", count, 4);
    chk("ovf_head", wb_rd_addr, 1);
    chk("ovf_pending", pending_rd, 32'h1E);

    // push and pop while full: both accepted
    wb_ready = 1'b1;
    tick();
    drive(1'b0, 5'd0, 32'd0);
    chk("pp_count", count, 4);
    chk("pp_pending", pending_rd, 32'h21C);
    for (int k = 0; k < 4; k++) begin
      chk("drain_rd", wb_rd_addr, (k == 3) ? 9 : k + 2);
      chk("drain_data", wb_data, (k == 3) ? 32'h909 : 32'h100 + k + 2);
      tick();
    end
    chk("drain_empty", wb_valid, 0);
    chk("ovf_sticky", overflow_err, 1);

    // x0 filtering at full, then freeze blocks push but not pop
    do_reset();
    wb_ready = 1'b0;
    for (int r = 10; r <= 13; r++) begin
      drive(1'b1, 5'(r), 32'h200 + r);
      tick();
    end
    drive(1'b1, 5'd0, 32'h0BAD);
    tick();
    chk("x0_count", count, 4);
    chk("x0_ovf", overflow_err, 0);
    freeze = 1'b1; wb_ready = 1'b1;
    drive(1'b1, 5'd6, 32'h606);
    tick();
    chk("frz_count", count, 3);
    chk("frz_head", wb_rd_addr, 11);
    chk("frz_pending", pending_rd, 32'h3800);
    chk("frz_ovf", overflow_err, 0);
    drive(1'b0, 5'd0, 32'd0); freeze = 1'b0;
    tick(); tick(); tick();
    chk("frz_drained", count, 0);

    // duplicate destination keeps pending bit until both pop
    wb_ready = 1'b0;
    drive(1'b1, 5'd8, 32'hA); tick();
    drive(1'b1, 5'd8, 32'hB); tick();
    drive(1'b0, 5'd0, 32'd0);
    chk("dup_pending2", pending_rd, 32'h100);
    wb_ready = 1'b1;
    tick();
    chk("dup_pending1", pending_rd, 32'h100);
    chk("dup_data", wb_data, 32'hB);
    tick();
    chk("dup_pending0", pending_rd, 0);

    // asynchronous reset with 3 entries and overflow set
    wb_ready = 1'b0;
    for (int r = 1; r <= 5; r++) begin
      drive(1'b1, 5'(r + 16), 32'h300 + r);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0);
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;
    chk("ar_pre_count", count, 3);
    chk("ar_pre_ovf", overflow_err, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", wb_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_pending", pending_rd, 0);
    chk("ar_ovf", overflow_err, 0);
    chk("ar_data", wb_data, 0);
    #3 rst = 1'b0;
    tick();
    chk("ar_after", wb_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
